axi_wr_sched: RTL
=================

// Module: axi_wr_sched
// PURPOSE
// - Write-transaction scheduler for the AXI interconnect: owns the AW/W/B muxes and decoders between masters and slaves.
// - Grants one master at a time with round-robin arbitration and decodes the target slave from the AW address.
// - Sequences the AW, W and B phases; holds the grant until the B handshake retires the transaction.
// - Outputs drive the mux/decoder select and enable lines; no payload passes through this block.
// PARAMETERS
// - NM           2      number of write-capable masters
// - ADDR_W       32     AW address width
// - SEL_BIT      16     address bit that selects the slave (0 -> S0, 1 -> S1)
// - TIMEOUT_CYC  1024   watchdog limit in cycles (used only with AXI_WR_TIMEOUT_EN)
// PORTS
// - ACLK         in   1          clock, rising edge
// - ARESETn      in   1          asynchronous active-low reset
// - awvalid_m    in   NM         per-master AWVALID
// - awaddr_m     in   NM*ADDR_W  per-master AWADDR, flattened; master i is at [i*ADDR_W +: ADDR_W]
// - awready_g    in   1          AWREADY of the selected slave
// - wvalid_g     in   1          WVALID of the granted master
// - wready_g     in   1          WREADY of the selected slave
// - wlast_g      in   1          WLAST of the granted master
// - bvalid_g     in   1          BVALID of the selected slave
// - bready_g     in   1          BREADY of the granted master
// - gnt          out  NM         one-hot master grant (mux select)
// - slv_sel      out  1          registered target slave index
// - aw_open      out  1          AW path enabled
// - w_open       out  1          W path enabled
// - b_open       out  1          B path enabled
// - busy         out  1          state != IDLE
// - timeout_err  out  1          one-cycle watchdog pulse (only with AXI_WR_TIMEOUT_EN)
// BEHAVIOUR
// - Reset (async, ARESETn=0) forces all outputs to 0, state IDLE and the RR pointer to master 0 (highest priority).
// - FSM states and transitions:
//   - IDLE -> AW when |awvalid_m. The winner is the first requester at or after the RR pointer, searching upward with wrap.
//   - AW: gnt and slv_sel are registered on entry, so aw_open rises 1 cycle after awvalid.
//   - AW -> W on awvalid_g&&awready_g, where awvalid_g = awvalid_m[granted].
//   - W -> B on wvalid_g&&wready_g&&wlast_g. Non-last beats keep the FSM in W. W data offered before AW completes is blocked (w_open=0).
//   - B -> IDLE on bvalid_g&&bready_g. The RR pointer moves to granted+1 mod NM, so the next request can be granted in the following IDLE cycle.
// - Output decode: aw_open=(AW), w_open=(W), b_open=(B). gnt and slv_sel stay stable from AW entry to B exit and are 0 in IDLE.
// - Grant changes only in IDLE. A new awvalid during AW/W/B is ignored until the FSM returns to IDLE.
// - Simultaneous requests are resolved by RR; a lone requester always wins regardless of pointer position.
// - If the granted master deasserts awvalid in AW (protocol violation), the FSM holds in AW and does not abort.
// - Single-beat burst: wlast on the first beat moves W -> B in one handshake.
// - Back-to-back handshakes in consecutive cycles are legal; each phase takes at least 1 cycle.
// - Reset asserted mid-transaction returns to IDLE immediately; no partial transaction is resumed.
// CONFIGURATION
// - AXI_WR_TIMEOUT_EN defined:
//   - A cycle counter clears on each phase transition and counts in W and B.
//   - On reaching TIMEOUT_CYC the FSM returns to IDLE, timeout_err pulses for 1 cycle, and the RR pointer advances.
// - AXI_WR_TIMEOUT_EN undefined: no counter; timeout_err is tied to 0; W and B wait indefinitely.
// STRUCTURE
// - Package axi_sched_pkg holds:
//   - typedef enum logic [1:0] {IDLE, AW, W, B} wr_state_e
//   - localparam SLV_S0=1'b0, SLV_S1=1'b1
//   - the IDS prefix width shared with the read scheduler
// - Sub-module rr_pick (combinational): inputs req[NM] and ptr, output one-hot winner. It is reused by the future read scheduler.
// TESTING
// - Single M0 write to S0, LEN=0: awvalid@t0 -> aw_open@t1; awready -> w_open; wlast beat -> b_open; bvalid&bready -> busy=0.
// - M0 and M1 request together, pointer=0 -> gnt=01. After B, M1 is still requesting -> gnt=10 with no idle gap beyond 1 cycle.
// - Addr bit16=1 with a 4-beat burst -> slv_sel=1; w_open stays high for all 4 beats and the FSM enters B only on the 4th (wlast) beat.
// - M1 raises awvalid while M0 is in W -> gnt stays 01 until B completes.
// - ARESETn pulsed low in W -> all outputs 0 asynchronously; after release, a pending awvalid is granted to master 0.
// - With AXI_WR_TIMEOUT_EN and TIMEOUT_CYC=16, no bvalid in B -> timeout_err pulse on the 16th cycle in B, then state IDLE.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI write/read transaction schedulers.
package axi_sched_pkg;

    typedef enum logic [1:0] {IDLE, AW, W, B} wr_state_e;

    localparam logic SLV_S0 = 1'b0;
    localparam logic SLV_S1 = 1'b1;

    // ID prefix width the interconnect prepends to identify the originating master
    localparam int unsigned IDS_W = 1;

    // Index width for n entries, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_wr_sched_rr_pick.sv
// Round-robin picker: one-hot winner is the first requester at or after ptr, wrapping upward.
module rr_pick
    import axi_sched_pkg::*;
#(
    parameter int unsigned NM    = 2,
    parameter int unsigned PTR_W = idx_w(NM)
) (
    input  logic [NM-1:0]    req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NM-1:0]    win_c
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        win_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NM);
            if (!found && req[idx]) begin
                win_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_sched.sv
// AXI write scheduler: RR master grant, slave decode and AW/W/B phase sequencing.
// Optional watchdog enabled by defining AXI_WR_TIMEOUT_EN.
module axi_wr_sched
    import axi_sched_pkg::*;
#(
    parameter int unsigned NM          = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SEL_BIT     = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [NM-1:0]        awvalid_m,
    input  logic [NM*ADDR_W-1:0] awaddr_m,
    input  logic                 awready_g,
    input  logic                 wvalid_g,
    input  logic                 wready_g,
    input  logic                 wlast_g,
    input  logic                 bvalid_g,
    input  logic                 bready_g,
    output logic [NM-1:0]        gnt,
    output logic                 slv_sel,
    output logic                 aw_open,
    output logic                 w_open,
    output logic                 b_open,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned PTR_W = idx_w(NM);

    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gidx_c;
    logic [PTR_W-1:0] ptr_nxt_c;
    logic [NM-1:0]    win_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic             sel_c;
    logic             awvalid_c;
    logic             tmo_c;
    logic             tmo_fire_c;

    rr_pick #(
        .NM    (NM),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (awvalid_m),
        .ptr   (ptr_q),
        .win_c (win_c)
    );

    // Address of the would-be winner, used to decode the target slave
    always_comb begin
        win_addr_c = '0;
        for (int i = 0; i < int'(NM); i++) begin
            if (win_c[i]) win_addr_c = awaddr_m[i*ADDR_W +: ADDR_W];
        end
    end

    logic unused_addr;
    assign unused_addr = ^win_addr_c;
    assign sel_c       = win_addr_c[SEL_BIT] ? SLV_S1 : SLV_S0;
    assign awvalid_c   = |(awvalid_m & gnt);

    // Index of the granted master; pointer resumes one past it
    always_comb begin
        gidx_c = '0;
        for (int i = 0; i < int'(NM); i++) begin
            if (gnt[i]) gidx_c = PTR_W'(i);
        end
        ptr_nxt_c = (gidx_c == PTR_W'(NM - 1)) ? '0 : gidx_c + PTR_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        tmo_fire_c = 1'b0;
        unique case (state_q)
            IDLE: if (|awvalid_m) state_d = AW;
            AW:   if (awvalid_c && awready_g) state_d = W;
            W: begin
                if (wvalid_g && wready_g && wlast_g) begin
                    state_d = B;
                end else if (tmo_c) begin
                    state_d    = IDLE;
                    tmo_fire_c = 1'b1;
                end
            end
            B: begin
                if (bvalid_g && bready_g) begin
                    state_d = IDLE;
                end else if (tmo_c) begin
                    state_d    = IDLE;
                    tmo_fire_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt     <= '0;
            slv_sel <= SLV_S0;
            aw_open <= 1'b0;
            w_open  <= 1'b0;
            b_open  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            aw_open <= (state_d == AW);
            w_open  <= (state_d == W);
            b_open  <= (state_d == B);
            busy    <= (state_d != IDLE);
            if (state_q == IDLE && state_d == AW) begin
                gnt     <= win_c;
                slv_sel <= sel_c;
            end else if (state_d == IDLE) begin
                gnt     <= '0;
                slv_sel <= SLV_S0;
            end
            if (state_q != IDLE && state_d == IDLE) ptr_q <= ptr_nxt_c;
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    localparam int unsigned CNT_W = idx_w(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;

    assign tmo_c = (state_q == W || state_q == B) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Phase-age counter; restarts on every phase change
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire_c;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == W || state_q == B) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
`else
    logic unused_tmo;
    assign tmo_c       = 1'b0;
    assign unused_tmo  = tmo_fire_c;
    assign timeout_err = 1'b0;
`endif

endmodule
